// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: widths, register-file depth and the
// architecturally named register indices.
package mips_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  typedef logic [ADDR_W-1:0] regfile_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_wdec.sv
// Write-port decoder: turns the destination index into a one-hot enable,
// gated by we. Bit 0 is never enabled so r0 stays hardwired to zero.
module reg_wdec #(
  parameter int ADDR_W = 5
) (
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] en
);

  always_comb begin
    en = '0;
    if (we) en[addr] = 1'b1;
    en[0] = 1'b0;
  end

endmodule

// File: rtl/reg_file.sv
// 32-entry MIPS register file: one write port, two combinational read ports,
// optional same-cycle write-to-read forwarding, r0 reads as zero.
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  wen;
  logic              fwd_ok;

  reg_wdec #(.ADDR_W(ADDR_W)) u_wdec (
    .we   (we),
    .addr (waddr),
    .en   (wen)
  );

  // Reset has priority over the write enable on the same edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n)      regs[i] <= '0;
      else if (wen[i]) regs[i] <= wdata;
    end
  end

  // Forwarding is only legal when the write will actually land this edge.
  assign fwd_ok = BYPASS && rst_n && we && (waddr != '0);

  always_comb begin
    rdata1 = regs[raddr1];
    if (fwd_ok && (raddr1 == waddr)) rdata1 = wdata;
    if (raddr1 == '0)                rdata1 = '0;
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (fwd_ok && (raddr2 == waddr)) rdata2 = wdata;
    if (raddr2 == '0)                rdata2 = '0;
  end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: bypassing and non-bypassing instances share stimulus and
// are checked each cycle against an array model plus directed literal cases.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n, we;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [32];
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b)
  );

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of a read, independent of how the RTL builds it.
  function automatic logic [31:0] expect_rd(input logic [4:0] ra, input bit byp);
    if (ra == 5'd0) return 32'h0;
    if (byp && rst_n && we && waddr != 5'd0 && waddr == ra) return wdata;
    return model[ra];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      chk_en = 1'b1;
    end else if (we && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_b_rd1", rd1_b, expect_rd(raddr1, 1'b1));
      check("model_b_rd2", rd2_b, expect_rd(raddr2, 1'b1));
      check("model_n_rd1", rd1_n, expect_rd(raddr1, 1'b0));
      check("model_n_rd2", rd2_n, expect_rd(raddr2, 1'b0));
    end
  end

  task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    rst_n = r; we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    edge_step();
    edge_step();
    mid();
    check("reset_rd1", rd1_b, 32'h0);

    // reset clears a previously written register
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    edge_step();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    mid();
    check("r5_written", rd1_n, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    edge_step();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    mid();
    check("r5_after_reset", rd1_b, 32'h0);

    // basic write/read
    drive(1'b1, 1'b1, 5'd8, 32'h12345678, 5'd1, 5'd2);
    edge_step();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
    mid();
    check("r8_rd1", rd1_n, 32'h12345678);
    check("r8_rd2", rd2_n, 32'h12345678);
    raddr2 = 5'd9;
    mid();
    check("r9_zero", rd2_n, 32'h0);

    // r0 stays zero, bypass included
    drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    mid();
    check("r0_pre_edge_b", rd1_b, 32'h0);
    edge_step();
    we = 1'b0;
    mid();
    check("r0_post_edge", rd1_b, 32'h0);

    // bypass vs. no bypass
    drive(1'b1, 1'b1, 5'd3, 32'h11111111, 5'd0, 5'd0);
    edge_step();
    drive(1'b1, 1'b1, 5'd4, 32'h44444444, 5'd0, 5'd0);
    edge_step();
    drive(1'b1, 1'b1, 5'd3, 32'h22222222, 5'd3, 5'd4);
    mid();
    check("byp_rd1", rd1_b, 32'h22222222);
    check("byp_rd2_old", rd2_b, 32'h44444444);
    check("nobyp_rd1_old", rd1_n, 32'h11111111);
    edge_step();
    we = 1'b0;
    mid();
    check("nobyp_rd1_new", rd1_n, 32'h22222222);

    // reset wins over a simultaneous write, and suppresses bypass
    drive(1'b1, 1'b1, 5'd7, 32'h00000077, 5'd0, 5'd0);
    edge_step();
    drive(1'b0, 1'b1, 5'd7, 32'hAAAA5555, 5'd7, 5'd3);
    mid();
    check("rst_no_bypass", rd1_b, 32'h00000077);
    edge_step();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd3);
    mid();
    check("rst_beats_write", rd1_b, 32'h0);
    check("rst_clears_r3", rd2_b, 32'h0);

    // sweep: r[i] = i
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b1, i[4:0], 32'(i), 5'd0, 5'd0);
      edge_step();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = i[4:0];
      raddr2 = 5'(31 - i);
      mid();
      check("sweep_rd1", rd1_n, 32'(i));
      check("sweep_rd2", rd2_b, 32'(31 - i));
    end

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(63) != 0), ($urandom_range(3) != 0),
            5'($urandom_range(31)), $urandom(),
            5'($urandom_range(31)), 5'($urandom_range(31)));
      if ($urandom_range(3) == 0) raddr1 = waddr;
      if ($urandom_range(3) == 0) raddr2 = waddr;
      edge_step();
    end

    mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS datapath.
- Acts as the write/distribute side of operand selection.
  - One write port: a decoded one-hot enable steers write-back data into exactly one register.
  - Two read ports select source operands rs/rt for the ALU.
- Sits between the write-back selector (ALU result / memory data / link PC) and the ALU operand inputs.

Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = read returns pre-write value

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- we  input  1  write enable for the write port
- waddr  input  ADDR_W  destination register index (rd/rt)
- wdata  input  DATA_W  write-back data
- raddr1  input  ADDR_W  read port 1 index (rs)
- raddr2  input  ADDR_W  read port 2 index (rt)
- rdata1  output  DATA_W  read port 1 data
- rdata2  output  DATA_W  read port 2 data

Behaviour:
- Storage: array regs[0..2**ADDR_W-1] of DATA_W bits.
- Reset:
  - Clock and reset are fixed: clk; rst_n is synchronous, active-low.
  - At a rising edge with rst_n=0, every entry is cleared to 0.
  - we is ignored during a reset edge; reset has priority over write.
  - A reset asserted in the middle of a program clears everything at that edge. No partial state is kept.
- Output reset value: rdata1/rdata2 = 0 from the first reset edge onward, because all entries are 0.
- Write:
  - At a rising edge with rst_n=1 and we=1, regs[waddr] <= wdata. Latency is 1 edge.
  - The 5-to-32 write decoder produces a one-hot enable; at most one entry changes per cycle.
- Register 0:
  - Hardwired zero. A write with waddr=0 is dropped and regs[0] stays 0.
  - A read of index 0 always returns 0, including under bypass.
- Read:
  - Combinational, zero latency: rdataN = regs[raddrN].
  - Both ports are independent and may address the same register.
- Bypass (BYPASS=1):
  - If we=1, rst_n=1, waddr!=0 and raddrN==waddr, then rdataN = wdata in the same cycle. This applies to each port independently.
  - Bypass is suppressed when rst_n=0; rdataN then shows the stored value.
- No bypass (BYPASS=0): rdataN shows the old value until the edge, and the new value after it.
- Undefined indices: none exist, since the full 2**ADDR_W range is implemented. No X may propagate on any read.
- No handshake: the datapath guarantees one write per cycle and no back-pressure.

Decomposition:
- Shared package (mips_pkg):
  - DATA_W, ADDR_W, REG_COUNT
  - REG_ZERO = 0 and named indices REG_RA = 31, REG_SP = 29 for link/stack use
  - regfile_addr_t and word_t typedefs
- One sub-module, reg_wdec:
  - Parameterised ADDR_W-to-2**ADDR_W one-hot decoder, gated by we.
  - Output bit 0 is forced low.
  - reg_file instantiates it; the storage array and read muxes stay in reg_file.

Test Plan:
- Reset clears state: write 0xDEADBEEF to r5 and release reset; hold rst_n=0 one edge; then raddr1=5 -> rdata1=0x00000000.
- Basic write/read: we=1, waddr=8, wdata=0x12345678, one edge; raddr1=8, raddr2=8 -> both 0x12345678; r9 still 0.
- r0 protection: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1 at raddr1=0 is 0 both before and after the edge.
- Bypass, BYPASS=1: r3=0x11111111; same cycle we=1, waddr=3, wdata=0x22222222, raddr1=3, raddr2=4 -> rdata1=0x22222222 and rdata2 = old r4. With BYPASS=0, rdata1=0x11111111 until the edge.
- Reset vs write: rst_n=0 and we=1, waddr=7, wdata=0xAAAA5555 on the same edge -> r7=0 afterwards, with no bypass during reset.
- Sweep: write index i to r1..r31 over consecutive cycles, then read all pairs -> rdata=i, r0=0, no X values.
